mul_div_unit_div: RTL and testbench
===================================

Name: mul_div_unit_div

Overview:
- Iterative 32-bit radix-2 integer divider in the EXE stage, beside the ALU.
- Takes the same two register operands as the ALU and implements the DIV/DIVU instructions.
- Results are written to LO (quotient) and HI (remainder).
- EXE stalls while the unit is busy. An exception or flush from MEM/WB aborts it through a cancel input.

Parameters:
- WIDTH, 32, operand and result width; only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- div_valid  input  1  start request; accepted only in IDLE
- div_signed  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled at accept
- div_src1  input  WIDTH  dividend (rs); sampled at accept
- div_src2  input  WIDTH  divisor (rt); sampled at accept
- div_cancel  input  1  flush; aborts any in-flight operation
- div_busy  output  1  high in CALC and DONE; EXE uses it to stall
- div_done  output  1  one-cycle pulse; quotient and remainder are valid in this cycle
- div_quot  output  WIDTH  quotient (to LO)
- div_rem  output  WIDTH  remainder (to HI)

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE, counter = 0.
  - div_busy = 0, div_done = 0, div_quot = 0, div_rem = 0.
  - Reset mid-operation discards all work; no done pulse follows.
- States:
  - IDLE:
    - div_valid=1 and div_cancel=0 at a rising edge: latch operands and sign mode; go to CALC with counter = 0.
    - Call the acceptance cycle cycle 0.
  - CALC:
    - One restoring shift-subtract step per cycle on the absolute values of the operands.
    - Steps run in cycles 1..32, counter 0..31.
    - After the step with counter = 31, go to DONE.
  - DONE (cycle 33):
    - div_done = 1; div_quot and div_rem hold the final values.
    - Next edge goes to IDLE.
- Latency: fixed 33 cycles from acceptance to div_done, including divide-by-zero.
- div_busy = 1 in cycles 1..33 and low in IDLE. EXE must hold div_valid until it sees div_done.
- Ignored requests: div_valid while in CALC or DONE is ignored, with no effect on the operation or results.
- Next accept: the earliest new accept is the cycle after DONE.
- Result hold:
  - div_quot and div_rem update only at the edge entering DONE.
  - They hold their value until the next DONE. Reset clears them.
- Signed rules (div_signed=1):
  - Operate on |src1| and |src2|.
  - The quotient is negated if src1[31]^src2[31].
  - The remainder is negated if src1[31]; its sign follows the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quot = 0x80000000, rem = 0 with no trap; overflow is not flagged.
- Divide by zero (src2 = 0, either mode):
  - quot = 0xFFFFFFFF, rem = src1 (the original, unmodified value).
  - Still takes 33 cycles.
- Cancel:
  - div_cancel=1 at any edge in CALC or DONE: go to IDLE next cycle.
  - No div_done is asserted in that next cycle; div_quot and div_rem keep their previous values.
  - If cancel is seen in the DONE cycle, the pulse already driven stands, but the results are not committed.
  - In IDLE, cancel together with div_valid: cancel wins and nothing is accepted.
- Width: internal partial remainder is WIDTH+1 bits; the shift register holding the quotient is WIDTH bits.
- No combinational path from the inputs to any output; all outputs are registered.

Test Plan:
- Unsigned basic: div_signed=0, src1=7, src2=2 at cycle 0.
  - div_busy high in cycles 1..33.
  - div_done high only in cycle 33, with quot=0x00000003, rem=0x00000001.
- Signed negatives:
  - src1=0xFFFFFFF9 (-7), src2=2 → quot=0xFFFFFFFD, rem=0xFFFFFFFF.
  - src1=7, src2=0xFFFFFFFE → quot=0xFFFFFFFD, rem=0x00000001.
- Corner cases:
  - Signed 0x80000000 / 0xFFFFFFFF → quot=0x80000000, rem=0.
  - Unsigned 0xFFFFFFFF / 1 → quot=0xFFFFFFFF, rem=0.
- Divide by zero, both modes:
  - src1=0x12345678, src2=0 → done at cycle 33, quot=0xFFFFFFFF, rem=0x12345678.
- Cancel and ignored request:
  - Start 100/7; pulse div_cancel in cycle 10 → state IDLE in cycle 11, no div_done, quot/rem keep their old values.
  - New start 100/7 in cycle 12 → done at cycle 45 with quot=14, rem=2.
  - div_valid held high through CALC with changing operands → does not disturb the operation.
- Reset and back-to-back:
  - Deassert resetn mid-CALC → outputs go to 0 immediately; no done pulse after release.
  - Two operations back-to-back with div_valid held high → second accept occurs in the cycle after the first DONE.

Source files
------------

// File: rtl/mul_div_unit_div.sv
// ---------------------------------------------------------------------------
// mul_div_unit_div
//   Iterative radix-2 restoring integer divider for the EXE stage (DIV/DIVU).
//   Quotient goes to LO, remainder to HI. Fixed latency: the request is
//   accepted in cycle 0, one shift-subtract step runs in each of cycles 1..32,
//   and results are presented with a one-cycle done pulse in cycle 33.
//
// Ports
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   div_valid   start request, accepted only while idle
//   div_signed  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
//   div_src1    dividend (rs); sampled at accept
//   div_src2    divisor (rt); sampled at accept
//   div_cancel  flush from MEM/WB; aborts any in-flight operation
//   div_busy    high while calculating and in the done cycle (EXE stall)
//   div_done    one-cycle pulse, results valid in this cycle
//   div_quot    quotient (held until the next completed operation)
//   div_rem     remainder (held until the next completed operation)
// ---------------------------------------------------------------------------
module mul_div_unit_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_valid,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] div_src1,
   input  logic [WIDTH-1:0] div_src2,
   input  logic             div_cancel,
   output logic             div_busy,
   output logic             div_done,
   output logic [WIDTH-1:0] div_quot,
   output logic [WIDTH-1:0] div_rem
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_sh_q, quo_sh_d;   // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dsr_q, dsr_d;         // |divisor|
   logic [WIDTH-1:0] prem_q, prem_d;       // partial remainder between steps
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;

   // Operand magnitudes at accept
   logic             src1_neg, src2_neg;
   logic [WIDTH-1:0] abs1, abs2;

   assign src1_neg = div_signed & div_src1[WIDTH-1];
   assign src2_neg = div_signed & div_src2[WIDTH-1];
   assign abs1     = src1_neg ? -div_src1 : div_src1;
   assign abs2     = src2_neg ? -div_src2 : div_src2;

   // One restoring step. The shifted partial remainder needs WIDTH+1 bits;
   // after a successful subtract it is below the divisor again, so the
   // WIDTH-bit difference is exact and the stored remainder fits WIDTH bits.
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             step_ok;
   logic [WIDTH-1:0] step_prem;
   logic [WIDTH-1:0] step_quo;
   logic [WIDTH-1:0] fin_quot;
   logic [WIDTH-1:0] fin_rem;

   assign shifted   = {prem_q, quo_sh_q[WIDTH-1]};
   assign step_ok   = (shifted >= {1'b0, dsr_q});
   assign diff      = shifted[WIDTH-1:0] - dsr_q;
   assign step_prem = step_ok ? diff : shifted[WIDTH-1:0];
   assign step_quo  = {quo_sh_q[WIDTH-2:0], step_ok};

   // Sign fix-up on the final step. A zero divisor naturally leaves
   // rem = |src1| (re-signed back to src1), but the quotient must be forced
   // to all ones since the sign rule would otherwise alter it.
   assign fin_quot = dz_q   ? '1 : (qneg_q ? -step_quo : step_quo);
   assign fin_rem  = rneg_q ? -step_prem : step_prem;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      quo_sh_d = quo_sh_q;
      dsr_d    = dsr_q;
      prem_d   = prem_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      done_d   = 1'b0;
      quot_d   = quot_q;
      rem_d    = rem_q;

      case (state_q)
         S_IDLE: begin
            // Cancel wins over a simultaneous request
            if (div_valid && !div_cancel) begin
               state_d  = S_CALC;
               cnt_d    = '0;
               quo_sh_d = abs1;
               dsr_d    = abs2;
               prem_d   = '0;
               qneg_d   = src1_neg ^ src2_neg;
               rneg_d   = src1_neg;
               dz_d     = (div_src2 == '0);
            end
         end
         S_CALC: begin
            if (div_cancel) begin
               state_d = S_IDLE;
            end else begin
               prem_d   = step_prem;
               quo_sh_d = step_quo;
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  quot_d  = fin_quot;
                  rem_d   = fin_rem;
               end
            end
         end
         S_DONE: begin
            // Requests here are ignored; earliest new accept is next cycle
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         quo_sh_q <= '0;
         dsr_q    <= '0;
         prem_q   <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         quot_q   <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         quo_sh_q <= quo_sh_d;
         dsr_q    <= dsr_d;
         prem_q   <= prem_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
      end
   end

   assign div_busy = busy_q;
   assign div_done = done_q;
   assign div_quot = quot_q;
   assign div_rem  = rem_q;

endmodule

// File: tb/tb_mul_div_unit_div.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit_div
//   Directed and randomized checks of mul_div_unit_div against an arithmetic
//   reference (SystemVerilog / and % with the divide-by-zero and overflow
//   rules applied explicitly). One line is printed per operation.
// ---------------------------------------------------------------------------
module tb_mul_div_unit_div;

   logic        clk;
   logic        resetn;
   logic        div_valid;
   logic        div_signed;
   logic [31:0] div_src1;
   logic [31:0] div_src2;
   logic        div_cancel;
   logic        div_busy;
   logic        div_done;
   logic [31:0] div_quot;
   logic [31:0] div_rem;

   int          checks;
   int          errors;
   logic [31:0] last_q;
   logic [31:0] last_r;

   mul_div_unit_div #(.WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .div_valid  (div_valid),
      .div_signed (div_signed),
      .div_src1   (div_src1),
      .div_src2   (div_src2),
      .div_cancel (div_cancel),
      .div_busy   (div_busy),
      .div_done   (div_done),
      .div_quot   (div_quot),
      .div_rem    (div_rem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural result of DIV/DIVU
   function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      int sa;
      int sb;
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'h0;
      end else begin
         sa = a;
         sb = b;
         q = sa / sb;
         r = sa % sb;
      end
   endfunction

   // Entered in cycle 0 (just after a rising edge, DUT idle). Returns at the
   // falling edge of cycle 33. With hold=1, div_valid stays high with
   // scrambled operands through the operation and is left high on return.
   task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input bit hold);
      logic [31:0] eq;
      logic [31:0] er;
      ref_div(sgn, a, b, eq, er);
      div_valid  = 1'b1;
      div_signed = sgn;
      div_src1   = a;
      div_src2   = b;
      @(negedge clk);
      check({tag, "_c0_busy"}, {31'b0, div_busy}, 32'd0);
      for (int cyc = 1; cyc <= 33; cyc++) begin
         @(posedge clk);
         #1;
         if (hold) begin
            div_signed = 1'($urandom);
            div_src1   = $urandom;
            div_src2   = $urandom;
         end else begin
            div_valid = 1'b0;
         end
         @(negedge clk);
         check($sformatf("%s_c%0d_busy_done", tag, cyc), {30'b0, div_busy, div_done},
               {30'b0, 1'b1, (cyc == 33)});
         if (cyc < 33) begin
            check($sformatf("%s_c%0d_qhold", tag, cyc), div_quot, last_q);
            check($sformatf("%s_c%0d_rhold", tag, cyc), div_rem, last_r);
         end
      end
      check({tag, "_quot"}, div_quot, eq);
      check({tag, "_rem"}, div_rem, er);
      $display("op %s signed=%0d a=%h b=%h quot=%h rem=%h exp_quot=%h exp_rem=%h",
               tag, sgn, a, b, div_quot, div_rem, eq, er);
      last_q = eq;
      last_r = er;
   endtask

   // From the falling edge of cycle 33: drop the request, confirm the done
   // pulse ended, and leave the bench just after a rising edge with DUT idle.
   task automatic finish_idle(input string tag);
      div_valid = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check({tag, "_after_busy_done"}, {30'b0, div_busy, div_done}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;

      checks     = 0;
      errors     = 0;
      last_q     = 32'h0;
      last_r     = 32'h0;
      resetn     = 1'b0;
      div_valid  = 1'b0;
      div_signed = 1'b0;
      div_src1   = 32'h0;
      div_src2   = 32'h0;
      div_cancel = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'b0, div_busy}, 32'd0);
      check("rst_done", {31'b0, div_done}, 32'd0);
      check("rst_quot", div_quot, 32'h0);
      check("rst_rem", div_rem, 32'h0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Directed arithmetic cases
      run_op("u7_2", 1'b0, 32'd7, 32'd2, 1'b0);
      finish_idle("u7_2");
      run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      finish_idle("s_m7_2");
      run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
      finish_idle("s_7_m2");
      run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      finish_idle("s_ovf");
      run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
      finish_idle("u_max_1");
      run_op("u_dz", 1'b0, 32'h1234_5678, 32'h0, 1'b0);
      finish_idle("u_dz");
      run_op("s_dz", 1'b1, 32'h1234_5678, 32'h0, 1'b0);
      finish_idle("s_dz");
      run_op("s_dz_neg", 1'b1, 32'h8765_4321, 32'h0, 1'b0);
      finish_idle("s_dz_neg");

      // Cancel in cycle 10: idle in cycle 11, no pulse, results unchanged
      div_valid  = 1'b1;
      div_signed = 1'b0;
      div_src1   = 32'd100;
      div_src2   = 32'd7;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk);
         #1;
         div_valid = 1'b0;
         if (cyc == 10) div_cancel = 1'b1;
      end
      @(posedge clk);
      #1;
      div_cancel = 1'b0;
      @(negedge clk);
      check("cancel_busy_done", {30'b0, div_busy, div_done}, 32'd0);
      check("cancel_quot", div_quot, last_q);
      check("cancel_rem", div_rem, last_r);
      $display("op cancel busy=%0d done=%0d quot=%h rem=%h", div_busy, div_done, div_quot, div_rem);
      @(posedge clk);
      #1;
      // Restart in cycle 12 with the request held and operands churning
      run_op("u100_7_hold", 1'b0, 32'd100, 32'd7, 1'b1);
      finish_idle("u100_7_hold");

      // Cancel together with a request in idle: nothing accepted
      div_valid  = 1'b1;
      div_cancel = 1'b1;
      div_src1   = 32'd9;
      div_src2   = 32'd3;
      @(posedge clk);
      #1;
      div_valid  = 1'b0;
      div_cancel = 1'b0;
      @(negedge clk);
      check("idle_cancel_busy", {31'b0, div_busy}, 32'd0);
      $display("op idle_cancel busy=%0d", div_busy);
      repeat (3) @(negedge clk);
      check("idle_cancel_no_done", {31'b0, div_done}, 32'd0);
      @(posedge clk);
      #1;

      // Back-to-back with div_valid held continuously
      run_op("b2b_first", 1'b0, 32'd1000, 32'd3, 1'b1);
      div_valid  = 1'b1;
      div_signed = 1'b1;
      div_src1   = 32'hFFFF_FF9C;
      div_src2   = 32'd7;
      @(posedge clk);
      #1;
      run_op("b2b_second", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
      finish_idle("b2b_second");

      // Reset mid-calculation clears outputs at once; no pulse afterwards
      div_valid  = 1'b1;
      div_signed = 1'b0;
      div_src1   = 32'd50;
      div_src2   = 32'd5;
      repeat (6) begin
         @(posedge clk);
         #1;
         div_valid = 1'b0;
      end
      resetn = 1'b0;
      #1;
      check("midrst_busy", {31'b0, div_busy}, 32'd0);
      check("midrst_done", {31'b0, div_done}, 32'd0);
      check("midrst_quot", div_quot, 32'h0);
      check("midrst_rem", div_rem, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (div_done) pulses++;
      end
      check("midrst_no_pulse", 32'(pulses), 32'd0);
      check("midrst_idle", {31'b0, div_busy}, 32'd0);
      $display("op midrst pulses=%0d busy=%0d", pulses, div_busy);
      last_q = 32'h0;
      last_r = 32'h0;
      @(posedge clk);
      #1;

      // Randomized operations
      for (int i = 0; i < 10; i++) begin
         rs = 1'($urandom);
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom_range(0, 15);
            1:       rb = -$urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         run_op($sformatf("rnd%0d", i), rs, ra, rb, 1'(i % 2));
         finish_idle($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
